// File: rtl/shake_share_arbiter_pkg.sv
// Shared definitions for the two-requester SHAKE core arbiter.
// State encoding is fixed so grant/busy decode stays trivial.
package shake_share_arbiter_pkg;

  localparam int DEFAULT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/shake_share_arbiter.sv
// Round-robin session arbiter sharing one keccak_top between two requesters.
// Owner paths are combinational pass-through; only state, ptr and drain count are stored.
module shake_share_arbiter
  import shake_share_arbiter_pkg::*;
#(
  parameter int W            = DEFAULT_W,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,

  input  logic         r0_din_valid,
  output logic         r0_din_ready,
  input  logic [W-1:0] r0_din,
  output logic         r0_dout_valid,
  input  logic         r0_dout_ready,
  output logic [W-1:0] r0_dout,
  input  logic         r0_force_done,

  input  logic         r1_din_valid,
  output logic         r1_din_ready,
  input  logic [W-1:0] r1_din,
  output logic         r1_dout_valid,
  input  logic         r1_dout_ready,
  output logic [W-1:0] r1_dout,
  input  logic         r1_force_done,

  output logic         sh_din_valid,
  input  logic         sh_din_ready,
  output logic [W-1:0] sh_din,
  input  logic         sh_dout_valid,
  output logic         sh_dout_ready,
  input  logic [W-1:0] sh_dout,
  output logic         sh_force_done,

  output logic [1:0]   grant,
  output logic         busy
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t     state, state_nxt;
  logic       ptr, ptr_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] own;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= 1'b0;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Non-owner force_done never reaches the transition logic.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (r0_din_valid && r1_din_valid) state_nxt = ptr ? ST_OWN1 : ST_OWN0;
        else if (r0_din_valid)            state_nxt = ST_OWN0;
        else if (r1_din_valid)            state_nxt = ST_OWN1;
      end
      ST_OWN0: begin
        if (r0_force_done) begin
          state_nxt = ST_DRAIN;
          ptr_nxt   = 1'b1;
          cnt_nxt   = DRAIN_LOAD;
        end
      end
      ST_OWN1: begin
        if (r1_force_done) begin
          state_nxt = ST_DRAIN;
          ptr_nxt   = 1'b0;
          cnt_nxt   = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (cnt == 4'd0) state_nxt = ST_IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Reset forces IDLE asynchronously, so every gated output below drops with rst_n.
  assign own   = {state == ST_OWN1, state == ST_OWN0};
  assign grant = own;
  assign busy  = (state != ST_IDLE);

  assign sh_din_valid  = (own[0] & r0_din_valid)  | (own[1] & r1_din_valid);
  assign sh_din        = own[0] ? r0_din : (own[1] ? r1_din : '0);
  assign sh_dout_ready = (own[0] & r0_dout_ready) | (own[1] & r1_dout_ready);
  assign sh_force_done = (own[0] & r0_force_done) | (own[1] & r1_force_done);

  assign r0_din_ready  = own[0] & sh_din_ready;
  assign r0_dout_valid = own[0] & sh_dout_valid;
  assign r0_dout       = own[0] ? sh_dout : '0;
  assign r1_din_ready  = own[1] & sh_din_ready;
  assign r1_dout_valid = own[1] & sh_dout_valid;
  assign r1_dout       = own[1] ? sh_dout : '0;

endmodule
